pce_rom_loader: RTL and testbench
=================================

// Module: pce_rom_loader
// PURPOSE
//  Write-path stage between the HPS ioctl download stream and the DDR3 ROM store.
//  - Turns each 16-bit ioctl word into one toggle-handshake write with an incrementing byte address.
//  - Applies optional per-byte bit reversal and throttles the HPS through dl_wait.
//  - At end of download, publishes ROM size and the 512-byte-header flag that the read path uses as its address offset.
// PARAMETERS
//  ADDR_W     24          byte-address width of ROM store
//  MAX_BYTES  24'h400000  capacity; words at or beyond this byte address are dropped
//  ACK_TO     4095        cycles to wait for wr_ack before declaring timeout
// PORTS
//  clk_sys    in   1       system clock
//  reset      in   1       asynchronous reset, active-high
//  dl_active  in   1       download in progress (ioctl_download)
//  dl_wr      in   1       1-cycle strobe: dl_data valid
//  dl_data    in   16      download word, little-endian byte pair
//  dl_wait    out  1       stall request to HPS
//  bit_swap   in   1       reverse bit order within each byte of dl_data
//  wr_addr    out  ADDR_W  byte address of current write, always even
//  wr_data    out  16      write data
//  wr_req     out  1       toggle: new write request
//  wr_ack     in   1       toggle: write done when wr_ack==wr_req
//  rom_size   out  8       final byte count [23:16]
//  hdr_skip   out  1       final byte count bit 9 (512-byte header present)
//  done       out  1       1-cycle pulse at dl_active fall
//  err        out  1       sticky: overflow | ack timeout | dl_wr while waiting; cleared at download start
// BEHAVIOUR
//  Reset values: dl_wait=0, wr_addr=0, wr_data=0, wr_req=0, rom_size=0, hdr_skip=0, done=0, err=0, state=IDLE.
//  States and transitions:
//   - IDLE: on dl_active 0->1 -> ARMED. Clear wr_addr and err; set wr_req<=wr_ack to resync toggles after any earlier reset.
//   - ARMED, dl_wr, wr_addr<MAX_BYTES:
//     - latch wr_data (bit-reversed per byte if bit_swap, sampled that cycle);
//     - toggle wr_req; dl_wait=1 next cycle; -> BUSY.
//   - ARMED, dl_wr, wr_addr>=MAX_BYTES:
//     - no request, err=1, dl_wait pulses one cycle;
//     - wr_addr still += 2 so rom_size reflects the true file length.
//   - BUSY, wr_ack==wr_req -> ARMED next cycle: dl_wait=0, wr_addr+=2. Minimum turnaround 2 cycles after dl_wr.
//   - BUSY, timeout counter reaches ACK_TO -> err=1, dl_wait=0, wr_addr+=2 -> ARMED. The word is treated as lost.
//   - dl_wr in BUSY: ignored, err=1, data not overwritten.
//   - ARMED|BUSY on dl_active 1->0: capture rom_size=wr_addr[23:16], hdr_skip=wr_addr[9]; done=1 for one cycle; -> IDLE.
//     If BUSY, the outstanding request is abandoned; its late ack has no effect.
//  Corner cases:
//   - Simultaneous dl_wr and dl_active fall: the word is dropped; sizes are captured from the pre-increment address.
//   - Reset mid-operation: all state clears asynchronously; next download start resyncs wr_req.
//   - Address is ADDR_W bits, with no wrap below 2^ADDR_W; MAX_BYTES guards overflow.
//  rom_size and hdr_skip are stable from done until the next download start, where they clear to 0.
//  The timeout counter is 12 bits; it clears on every request issue.
// STRUCTURE
//  Package pce_loader_pkg:
//   - state enum {IDLE, ARMED, BUSY};
//   - WORD_STEP=2;
//   - function rev8(byte) for bit reversal.
//  Single module; no sub-module. The ack-timeout counter is inline.
// TESTING
//  1. reset, dl_active 1, write 0x1234, 0xABCD, ack each after 3 cycles:
//     wr_addr 0 then 2; wr_data 0x1234 then 0xABCD; wr_req toggles twice; dl_wait high exactly during each wait.
//  2. bit_swap=1, dl_data=0x0180 -> wr_data=0x8001.
//  3. Download 0x40200 bytes, then drop dl_active: done pulse; rom_size=0x04; hdr_skip=1; err=0.
//  4. Withhold wr_ack for 4095 cycles: err=1, dl_wait drops, next word goes to wr_addr+2.
//  5. MAX_BYTES=16, write 10 words: 8 requests, 2 dropped; err=1; rom_size=0; final wr_addr=20.
//  6. Assert reset while BUSY, release, start a new download:
//     wr_req resynced to wr_ack; first write at addr 0; err=0.

Source files
------------

// File: rtl/pce_loader_pkg.sv
// pce_loader_pkg: shared types and helpers for the ROM download write path.
package pce_loader_pkg;

   typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_t;

   localparam int WORD_STEP = 2;

   function automatic logic [7:0] rev8(input logic [7:0] b);
      for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
   endfunction

endpackage

// File: rtl/pce_rom_loader.sv
// pce_rom_loader: turns the ioctl download word stream into toggle-handshake
// ROM store writes and publishes the final ROM size / header flag.
module pce_rom_loader
   import pce_loader_pkg::*;
#(
   parameter int               ADDR_W    = 24,
   parameter logic [ADDR_W-1:0] MAX_BYTES = ADDR_W'(24'h400000),
   parameter logic [11:0]      ACK_TO    = 12'd4095
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [15:0]       dl_data,
   output logic              dl_wait,
   input  logic              bit_swap,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              wr_req,
   input  logic              wr_ack,
   output logic [7:0]        rom_size,
   output logic              hdr_skip,
   output logic              done,
   output logic              err
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic              req_q, req_d;
   logic              wait_q, wait_d;
   logic [7:0]        size_q, size_d;
   logic              hdr_q, hdr_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              act_q, act_d;
   logic [11:0]       cnt_q, cnt_d;
   logic              rise, fall;
   logic [ADDR_W-1:0] addr_nxt;

   assign rise     = dl_active & ~act_q;
   assign fall     = ~dl_active & act_q;
   assign addr_nxt = addr_q + ADDR_W'(WORD_STEP);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      req_d   = req_q;
      wait_d  = wait_q;
      size_d  = size_q;
      hdr_d   = hdr_q;
      done_d  = 1'b0;
      err_d   = err_q;
      cnt_d   = cnt_q;
      act_d   = dl_active;
      case (state_q)
         IDLE: if (rise) begin
            // wr_req may be out of phase with wr_ack after a reset; realign first
            state_d = ARMED;
            addr_d  = '0;
            err_d   = 1'b0;
            req_d   = wr_ack;
            size_d  = 8'd0;
            hdr_d   = 1'b0;
         end
         ARMED: begin
            wait_d = dl_wr & ~fall;
            if (fall) begin
               size_d  = addr_q[23:16];
               hdr_d   = addr_q[9];
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (dl_wr && addr_q < MAX_BYTES) begin
               data_d  = bit_swap ? {rev8(dl_data[15:8]), rev8(dl_data[7:0])} : dl_data;
               req_d   = ~req_q;
               cnt_d   = 12'd0;
               state_d = BUSY;
            end else if (dl_wr) begin
               // dropped word still counts toward the file length
               err_d  = 1'b1;
               addr_d = addr_nxt;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 12'd1;
            if (dl_wr) err_d = 1'b1;
            if (fall) begin
               size_d  = addr_q[23:16];
               hdr_d   = addr_q[9];
               done_d  = 1'b1;
               wait_d  = 1'b0;
               state_d = IDLE;
            end else if (wr_ack == req_q || cnt_q == ACK_TO) begin
               if (wr_ack != req_q) err_d = 1'b1;
               wait_d  = 1'b0;
               addr_d  = addr_nxt;
               state_d = ARMED;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= 16'd0;
         req_q   <= 1'b0;
         wait_q  <= 1'b0;
         size_q  <= 8'd0;
         hdr_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         act_q   <= 1'b0;
         cnt_q   <= 12'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         req_q   <= req_d;
         wait_q  <= wait_d;
         size_q  <= size_d;
         hdr_q   <= hdr_d;
         done_q  <= done_d;
         err_q   <= err_d;
         act_q   <= act_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dl_wait  = wait_q;
   assign wr_addr  = addr_q;
   assign wr_data  = data_q;
   assign wr_req   = req_q;
   assign rom_size = size_q;
   assign hdr_skip = hdr_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_pce_rom_loader.sv
// tb_pce_rom_loader: directed bench for pce_rom_loader (default instance a,
// small-capacity instance b with MAX_BYTES=16).
module tb_pce_rom_loader;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        bit_swap = 1'b0;
   logic [15:0] dat = 16'd0;

   logic a_act = 0, a_wr = 0, a_ack = 0, a_hold = 1;
   logic a_wait, a_req, a_hdr, a_done, a_err;
   logic [23:0] a_addr;
   logic [15:0] a_wdat;
   logic [7:0]  a_size;

   logic b_act = 0, b_wr = 0, b_ack = 0;
   logic b_wait, b_req, b_hdr, b_done, b_err;
   logic [23:0] b_addr;
   logic [15:0] b_wdat;
   logic [7:0]  b_size;

   int n_cmp = 0, n_bad = 0;
   int b_tog = 0, t0;
   logic b_prev = 1'b0;
   logic r;

   always #5 clk_sys = ~clk_sys;

   pce_rom_loader u_a (
      .clk_sys(clk_sys), .reset(reset), .dl_active(a_act), .dl_wr(a_wr), .dl_data(dat),
      .dl_wait(a_wait), .bit_swap(bit_swap), .wr_addr(a_addr), .wr_data(a_wdat),
      .wr_req(a_req), .wr_ack(a_ack), .rom_size(a_size), .hdr_skip(a_hdr),
      .done(a_done), .err(a_err)
   );

   pce_rom_loader #(.MAX_BYTES(24'd16)) u_b (
      .clk_sys(clk_sys), .reset(reset), .dl_active(b_act), .dl_wr(b_wr), .dl_data(dat),
      .dl_wait(b_wait), .bit_swap(bit_swap), .wr_addr(b_addr), .wr_data(b_wdat),
      .wr_req(b_req), .wr_ack(b_ack), .rom_size(b_size), .hdr_skip(b_hdr),
      .done(b_done), .err(b_err)
   );

   // immediate-ack memory models
   initial forever begin
      @(negedge clk_sys);
      if (!a_hold && a_req !== a_ack) a_ack = a_req;
   end

   initial forever begin
      @(negedge clk_sys);
      if (b_req !== b_ack) b_ack = b_req;
   end

   initial forever begin
      @(negedge clk_sys);
      if (b_req !== b_prev) b_tog++;
      b_prev = b_req;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic burst(input bit s, input int n);
      for (int i = 0; i < n; i++) begin
         dat = 16'(i);
         if (s) b_wr = 1'b1; else a_wr = 1'b1;
         @(negedge clk_sys);
         a_wr = 1'b0;
         b_wr = 1'b0;
         @(negedge clk_sys);
      end
   endtask

   initial begin
      @(negedge clk_sys);
      check("rst dl_wait", a_wait, 0);
      check("rst wr_addr", a_addr, 0);
      check("rst wr_data", a_wdat, 0);
      check("rst wr_req", a_req, 0);
      check("rst rom_size", a_size, 0);
      check("rst hdr_skip", a_hdr, 0);
      check("rst done", a_done, 0);
      check("rst err", a_err, 0);
      reset = 1'b0;

      // 1: two words, ack 3 cycles after each request
      @(negedge clk_sys);
      a_act = 1'b1;
      @(negedge clk_sys);
      a_wr = 1'b1; dat = 16'h1234;
      @(negedge clk_sys);
      check("t1 addr0", a_addr, 0);
      check("t1 data0", a_wdat, 16'h1234);
      check("t1 req0", a_req, 1);
      check("t1 wait0", a_wait, 1);
      a_wr = 1'b0;
      repeat (2) begin @(negedge clk_sys); check("t1 wait0 held", a_wait, 1); end
      a_ack = 1'b1;
      @(negedge clk_sys);
      check("t1 wait0 drop", a_wait, 0);
      check("t1 addr1", a_addr, 2);
      a_wr = 1'b1; dat = 16'hABCD;
      @(negedge clk_sys);
      check("t1 data1", a_wdat, 16'hABCD);
      check("t1 req1", a_req, 0);
      check("t1 wait1", a_wait, 1);
      a_wr = 1'b0;
      repeat (2) begin @(negedge clk_sys); check("t1 wait1 held", a_wait, 1); end
      a_ack = 1'b0;
      @(negedge clk_sys);
      check("t1 wait1 drop", a_wait, 0);
      check("t1 addr2", a_addr, 4);
      a_hold = 1'b0;

      // 2: bit reversal within each byte
      bit_swap = 1'b1;
      a_wr = 1'b1; dat = 16'h0180;
      @(negedge clk_sys);
      check("t2 swap 0180", a_wdat, 16'h8001);
      a_wr = 1'b0;
      @(negedge clk_sys);
      a_wr = 1'b1; dat = 16'h12F0;
      @(negedge clk_sys);
      check("t2 swap 12f0", a_wdat, 16'h480F);
      a_wr = 1'b0;
      bit_swap = 1'b0;
      @(negedge clk_sys);
      check("t2 addr", a_addr, 8);

      // 3: download 0x200 bytes then end
      burst(0, 252);
      check("t3 addr", a_addr, 24'h200);
      a_act = 1'b0;
      @(negedge clk_sys);
      check("t3 done", a_done, 1);
      check("t3 rom_size", a_size, 0);
      check("t3 hdr_skip", a_hdr, 1);
      check("t3 err", a_err, 0);
      @(negedge clk_sys);
      check("t3 done end", a_done, 0);
      check("t3 hdr hold", a_hdr, 1);

      // 4: ack withheld until timeout
      a_act = 1'b1;
      @(negedge clk_sys);
      check("t4 size clr", a_size, 0);
      check("t4 hdr clr", a_hdr, 0);
      check("t4 addr clr", a_addr, 0);
      a_hold = 1'b1;
      a_wr = 1'b1; dat = 16'h5A5A;
      @(negedge clk_sys);
      a_wr = 1'b0;
      repeat (4095) @(negedge clk_sys);
      check("t4 pre-to wait", a_wait, 1);
      check("t4 pre-to err", a_err, 0);
      @(negedge clk_sys);
      check("t4 to wait", a_wait, 0);
      check("t4 to err", a_err, 1);
      check("t4 to addr", a_addr, 2);
      a_wr = 1'b1; dat = 16'h7777;
      @(negedge clk_sys);
      check("t4 next addr", a_addr, 2);
      check("t4 next data", a_wdat, 16'h7777);
      a_wr = 1'b0;
      @(negedge clk_sys);
      check("t4 next done addr", a_addr, 4);
      r = a_req;
      a_wr = 1'b1; a_act = 1'b0;
      @(negedge clk_sys);
      a_wr = 1'b0;
      check("t4 fall done", a_done, 1);
      check("t4 fall no req", a_req, r);
      check("t4 fall addr", a_addr, 4);
      check("t4 fall hdr", a_hdr, 0);

      // 5: capacity 16 bytes, 10 words
      b_act = 1'b1;
      repeat (2) @(negedge clk_sys);
      t0 = b_tog;
      burst(1, 8);
      check("t5 toggles", b_tog - t0, 8);
      check("t5 addr16", b_addr, 16);
      check("t5 err pre", b_err, 0);
      b_wr = 1'b1;
      @(negedge clk_sys);
      b_wr = 1'b0;
      check("t5 drop wait", b_wait, 1);
      check("t5 drop err", b_err, 1);
      check("t5 drop addr", b_addr, 18);
      @(negedge clk_sys);
      check("t5 drop wait end", b_wait, 0);
      b_wr = 1'b1;
      @(negedge clk_sys);
      b_wr = 1'b0;
      @(negedge clk_sys);
      check("t5 final addr", b_addr, 20);
      check("t5 toggles end", b_tog - t0, 8);
      b_act = 1'b0;
      @(negedge clk_sys);
      check("t5 done", b_done, 1);
      check("t5 rom_size", b_size, 0);
      check("t5 err sticky", b_err, 1);

      // long file on small store: length still tracked past capacity
      b_act = 1'b1;
      @(negedge clk_sys);
      check("big err clr", b_err, 0);
      burst(1, 8);
      b_wr = 1'b1;
      repeat (33016) @(negedge clk_sys);
      b_wr = 1'b0;
      check("big addr", b_addr, 24'h10200);
      b_act = 1'b0;
      @(negedge clk_sys);
      check("big rom_size", b_size, 8'h01);
      check("big hdr_skip", b_hdr, 1);
      check("big done", b_done, 1);

      // 6: reset while busy, then resync
      a_ack = 1'b1;
      a_act = 1'b1;
      @(negedge clk_sys);
      check("t6 resync pre", a_req, 1);
      a_wr = 1'b1; dat = 16'h1111;
      @(negedge clk_sys);
      check("t6 busy req", a_req, 0);
      dat = 16'h2222;
      @(negedge clk_sys);
      a_wr = 1'b0;
      check("t6 busy wr err", a_err, 1);
      check("t6 busy keep data", a_wdat, 16'h1111);
      reset = 1'b1; a_act = 1'b0;
      #1;
      check("t6 async req", a_req, 0);
      check("t6 async wait", a_wait, 0);
      check("t6 async err", a_err, 0);
      check("t6 async addr", a_addr, 0);
      @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
      a_act = 1'b1;
      @(negedge clk_sys);
      check("t6 resync req", a_req, 1);
      a_wr = 1'b1; dat = 16'h3333;
      @(negedge clk_sys);
      a_wr = 1'b0;
      check("t6 first addr", a_addr, 0);
      check("t6 first req", a_req, 0);
      check("t6 first data", a_wdat, 16'h3333);
      check("t6 err", a_err, 0);
      a_hold = 1'b0;
      repeat (2) @(negedge clk_sys);
      check("t6 ack wait", a_wait, 0);
      check("t6 ack addr", a_addr, 2);
      a_act = 1'b0;
      @(negedge clk_sys);
      check("t6 done", a_done, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
